// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from the UART receiver and commits each
// checksum-verified payload to the register file as a burst of consecutive writes.
module uart_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       pkt_done,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_FIRE  = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [7:0]       base_q, base_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       pay_q [MAX_LEN];
  logic [7:0]       pay_d [MAX_LEN];
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overrun_q, err_overrun_d;
  logic             in_frame;

  assign in_frame = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    chk_d         = chk_q;
    pay_d         = pay_q;
    tmr_d         = '0;
    wr_en_d       = 1'b0;
    wr_addr_d     = 8'h00;
    wr_data_d     = 8'h00;
    pkt_done_d    = 1'b0;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    if (in_frame && !rx_data_ready) tmr_d = tmr_q + TMR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (rx_data_ready && rx_data == SYNC_BYTE) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rx_data_ready) begin
          base_d  = rx_data;
          chk_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_data_ready) begin
          if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_data[CNT_W-1:0];
            cnt_d   = '0;
            chk_d   = chk_q ^ rx_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_data_ready) begin
          pay_d[cnt_q[IDX_W-1:0]] = rx_data;
          chk_d = chk_q ^ rx_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) state_d = S_CHK;
        end
      end
      S_CHK: begin
        // The first write is launched here so wr_en rises the cycle after the CHK byte.
        if (rx_data_ready) begin
          if (rx_data == chk_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = pay_q[0];
            cnt_d     = CNT_W'(1);
            state_d   = S_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q < len_q) begin
          wr_en_d       = 1'b1;
          wr_addr_d     = base_q + 8'(cnt_q);
          wr_data_d     = pay_q[cnt_q[IDX_W-1:0]];
          cnt_d         = cnt_q + CNT_W'(1);
          err_overrun_d = rx_data_ready;
        end else begin
          pkt_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every in-frame branch above needs a byte, so a timeout never collides with one.
    if (in_frame && !rx_data_ready && tmr_q == TMR_FIRE) begin
      err_timeout_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_q        <= 8'h00;
      len_q         <= '0;
      cnt_q         <= '0;
      chk_q         <= 8'h00;
      tmr_q         <= '0;
      pay_q         <= '{default: 8'h00};
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 8'h00;
      wr_data_q     <= 8'h00;
      pkt_done_q    <= 1'b0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      chk_q         <= chk_d;
      tmr_q         <= tmr_d;
      pay_q         <= pay_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      pkt_done_q    <= pkt_done_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != S_IDLE);
  assign pkt_done    = pkt_done_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
endmodule
